rptr_empty_ctrl: RTL and testbench
==================================

RPTR_EMPTY_CTRL -- requirements
Module: rptr_empty_ctrl

Interface
REQ-001 SHALL have parameter AEMPTY_THRESH, default 2, meaning raempty asserts when occupancy <= this value.
REQ-002 SHALL take ADDRSIZE (default 9, 512-entry FIFO) from package definitions; pointer width is ADDRSIZE+1.
REQ-003 SHALL have port rclk  input  1  read-domain clock.
REQ-004 SHALL have port rrst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rinc  input  1  read request.
REQ-006 SHALL have port wptr  input  ADDRSIZE+1  Gray write pointer from the write domain (asynchronous to rclk).
REQ-007 SHALL have port raddr  output  ADDRSIZE  binary read address to the FIFO memory.
REQ-008 SHALL have port rptr  output  ADDRSIZE+1  registered Gray read pointer, sent to the write domain.
REQ-009 SHALL have port rempty  output  1  FIFO empty.
REQ-010 SHALL have port raempty  output  1  FIFO almost empty.
REQ-011 SHALL have port rlevel  output  ADDRSIZE+1  registered read-side occupancy.
REQ-012 SHALL have port runderflow  output  1  sticky underflow error (present only under RPTR_UNDERFLOW_CHK_EN).

Function
REQ-013 SHALL synchronize wptr through two rclk flops (rq1_wptr, rq2_wptr); only rq2_wptr is used by read logic.
REQ-014 SHALL advance the binary read pointer rbin by 1 on a rclk edge iff rinc=1 and rempty=0; rinc with rempty=1 leaves all pointers unchanged.
REQ-015 SHALL compute rgraynext = (rbinnext>>1)^rbinnext and register it as rptr; raddr = rbin[ADDRSIZE-1:0].
REQ-016 SHALL register rempty = (rgraynext == rq2_wptr); a wptr change becomes visible on rempty on the 3rd rclk edge after it is stable.
REQ-017 SHALL register rlevel = gray2bin(rq2_wptr) - rbinnext, modulo 2^(ADDRSIZE+1); full FIFO gives rlevel = 2^ADDRSIZE.
REQ-018 SHALL register raempty = (next rlevel <= AEMPTY_THRESH).
REQ-019 SHALL wrap rbin from 2^(ADDRSIZE+1)-1 to 0 with no glitch on rempty; the MSB toggle distinguishes laps.
REQ-020 SHALL, on a read of the last entry coinciding with a new write arriving on rq2_wptr, evaluate rempty from both next values in the same cycle (rempty stays 0).
REQ-021 SHALL change exactly one bit of rptr per increment.

Reset
REQ-022 SHALL, while rrst=1 (asynchronously), force rbin=0, rptr=0, rq1_wptr=0, rq2_wptr=0, rempty=1, raempty=1, rlevel=0, runderflow=0.
REQ-023 SHALL abandon any read in progress when reset asserts mid-operation; first valid read is on the first rclk edge after rrst deasserts.

Configuration
REQ-024 SHALL, with RPTR_UNDERFLOW_CHK_EN defined, set runderflow on any rclk edge with rinc=1 and rempty=1 and hold it until rrst.
REQ-025 SHALL, without RPTR_UNDERFLOW_CHK_EN, omit the runderflow port and its flop entirely; all other behaviour identical.

Structure
REQ-026 SHALL place ADDRSIZE, the pointer typedef (logic [ADDRSIZE:0]) and the gray2bin/bin2gray functions in package definitions.
REQ-027 SHALL instantiate one sub-module sync_w2r (2-flop synchronizer, rclk/rrst) for the wptr crossing.

Verification
REQ-028 Reset: assert rrst mid-stream with rbin=37 -> rptr=0, rempty=1, raempty=1, rlevel=0 immediately, without a clock edge.
REQ-029 Latency: from reset, wptr 0->1 (Gray 1) -> rempty falls on 3rd rclk edge, rlevel=1, raempty=1.
REQ-030 Drain: wptr = bin2gray(5), five rinc pulses -> rlevel 4,3,2,1,0; raempty asserts at rlevel=2; rempty=1 after 5th read.
REQ-031 Underflow: rinc=1 while empty -> rptr unchanged; with RPTR_UNDERFLOW_CHK_EN runderflow=1 and stays 1 until rrst.
REQ-032 Wrap: preload so rbin=1023, wptr=bin2gray(0)+1 entry -> read gives rbin=0, rptr=0, rempty=1, single-bit rptr change.
REQ-033 Full: wptr = bin2gray(512) with rbin=0 -> rlevel=512, rempty=0, raempty=0.

Source files
------------

// File: rtl/rptr_empty_ctrl_pkg.sv
// Shared definitions for the FIFO read-pointer / empty-flag controller:
// the address size, the Gray/binary pointer type and the pointer conversion helpers.
package definitions;

    localparam int ADDRSIZE = 9;

    typedef logic [ADDRSIZE:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_ctrl_sync_w2r.sv
// Two-flop synchronizer that carries the Gray write pointer into the read clock domain.
module sync_w2r
    import definitions::*;
(
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   rq2_wptr
);

    ptr_t rq1_wptr_q, rq1_wptr_d;
    ptr_t rq2_wptr_q, rq2_wptr_d;

    always_comb begin
        rq1_wptr_d = wptr;
        rq2_wptr_d = rq1_wptr_q;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rq1_wptr_q <= '0;
            rq2_wptr_q <= '0;
        end else begin
            rq1_wptr_q <= rq1_wptr_d;
            rq2_wptr_q <= rq2_wptr_d;
        end
    end

    assign rq2_wptr = rq2_wptr_q;

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer, empty/almost-empty and occupancy logic of an async FIFO.
// Optional sticky underflow flag is built when RPTR_UNDERFLOW_CHK_EN is defined.
module rptr_empty_ctrl
    import definitions::*;
#(
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel
`ifdef RPTR_UNDERFLOW_CHK_EN
    ,
    output logic                runderflow
`endif
);

    localparam ptr_t AEMPTY_LIMIT = ptr_t'(AEMPTY_THRESH);

    ptr_t rq2_wptr;

    ptr_t rbin_q,    rbin_d;
    ptr_t rptr_q,    rptr_d;
    logic rempty_q,  rempty_d;
    logic raempty_q, raempty_d;
    ptr_t rlevel_q,  rlevel_d;

    ptr_t rgraynext;

    sync_w2r u_sync_w2r (
        .rclk     (rclk),
        .rrst     (rrst),
        .wptr     (wptr),
        .rq2_wptr (rq2_wptr)
    );

    // Empty and level both use the next read pointer, so a final read racing a new write stays non-empty.
    always_comb begin
        rbin_d    = rbin_q + ptr_t'(rinc & ~rempty_q);
        rgraynext = bin2gray(rbin_d);
        rptr_d    = rgraynext;
        rempty_d  = (rgraynext == rq2_wptr);
        rlevel_d  = gray2bin(rq2_wptr) - rbin_d;
        raempty_d = (rlevel_d <= AEMPTY_LIMIT);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            rlevel_q  <= '0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
            rlevel_q  <= rlevel_d;
        end
    end

`ifdef RPTR_UNDERFLOW_CHK_EN
    logic runderflow_q, runderflow_d;

    always_comb begin
        runderflow_d = runderflow_q | (rinc & rempty_q);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            runderflow_q <= 1'b0;
        end else begin
            runderflow_q <= runderflow_d;
        end
    end

    assign runderflow = runderflow_q;
`endif

    assign raddr   = rbin_q[ADDRSIZE-1:0];
    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign raempty = raempty_q;
    assign rlevel  = rlevel_q;

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Self-checking bench for rptr_empty_ctrl: directed scenarios plus random traffic
// compared against a read-count / write-count occupancy model.
module tb_rptr_empty_ctrl;

    localparam int AW    = 9;
    localparam int PMOD  = 1024;
    localparam int DEPTH = 512;
    localparam int THR   = 2;

    logic          rclk;
    logic          rrst;
    logic          rinc;
    logic [AW:0]   wptr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rlevel;
`ifdef RPTR_UNDERFLOW_CHK_EN
    logic          runderflow;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: counts of entries written and read, with the write count
    // seen by the reader delayed through a two-stage history.
    int wbin      = 0;
    int m_rcount  = 0;
    int m_level   = 0;
    int m_hist0   = 0;
    int m_hist1   = 0;
    bit m_empty   = 1'b1;
    bit m_under   = 1'b0;
    int prev_rcount = 0;
    logic [AW:0] prev_rptr = '0;

    rptr_empty_ctrl #(.AEMPTY_THRESH(THR)) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rinc    (rinc),
        .wptr    (wptr),
        .raddr   (raddr),
        .rptr    (rptr),
        .rempty  (rempty),
        .raempty (raempty),
        .rlevel  (rlevel)
`ifdef RPTR_UNDERFLOW_CHK_EN
        ,
        .runderflow (runderflow)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic int gray(input int v);
        return (v ^ (v >> 1)) % PMOD;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        chk("raddr",   {22'b0, raddr},  m_rcount % DEPTH);
        chk("rptr",    {22'b0, rptr},   gray(m_rcount));
        chk("rempty",  {31'b0, rempty}, {31'b0, m_empty});
        chk("raempty", {31'b0, raempty}, (m_level <= THR) ? 1 : 0);
        chk("rlevel",  {22'b0, rlevel}, m_level);
`ifdef RPTR_UNDERFLOW_CHK_EN
        chk("runderflow", {31'b0, runderflow}, {31'b0, m_under});
`endif
        if (m_rcount != prev_rcount)
            chk("rptr_onebit", $countones(prev_rptr ^ rptr), 1);
        prev_rcount = m_rcount;
        prev_rptr   = rptr;
    endtask

    // One rclk edge: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic apply_stimulus(input logic inc);
        rinc = inc;
        wptr = (AW+1)'(gray(wbin));
        @(posedge rclk);
        if (inc) begin
            if (m_empty) m_under = 1'b1;
            else         m_rcount = (m_rcount + 1) % PMOD;
        end
        m_level = (m_hist1 - m_rcount + PMOD) % PMOD;
        m_empty = (m_level == 0);
        m_hist1 = m_hist0;
        m_hist0 = wbin;
        #1;
        check_output();
    endtask

    // Asserts reset between edges and checks the outputs before any edge arrives.
    task automatic do_reset();
        rinc = 1'b0;
        #2;
        rrst = 1'b1;
        #1;
        m_rcount = 0; m_level = 0; m_hist0 = 0; m_hist1 = 0;
        m_empty = 1'b1; m_under = 1'b0;
        chk("rst_rptr",    {22'b0, rptr},    0);
        chk("rst_rempty",  {31'b0, rempty},  1);
        chk("rst_raempty", {31'b0, raempty}, 1);
        chk("rst_rlevel",  {22'b0, rlevel},  0);
        prev_rcount = 0;
        prev_rptr   = '0;
        @(posedge rclk);
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    initial begin
        int guard;
        rrst = 1'b1;
        rinc = 1'b0;
        wptr = '0;
        $display("[TB] start");
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rrst = 1'b0;
        #0 check_output();

        // Latency: one write appears on rempty at the third edge.
        wbin = 1;
        apply_stimulus(1'b0);
        chk("lat_edge1_rempty", {31'b0, rempty}, 1);
        apply_stimulus(1'b0);
        chk("lat_edge2_rempty", {31'b0, rempty}, 1);
        apply_stimulus(1'b0);
        chk("lat_edge3_rempty",  {31'b0, rempty},  0);
        chk("lat_edge3_rlevel",  {22'b0, rlevel},  1);
        chk("lat_edge3_raempty", {31'b0, raempty}, 1);

        // Drain five entries.
        do_reset();
        wbin = 5;
        repeat (3) apply_stimulus(1'b0);
        chk("drain_start_raempty", {31'b0, raempty}, 0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1);
            chk("drain_rlevel",  {22'b0, rlevel},  4 - i);
            chk("drain_raempty", {31'b0, raempty}, ((4 - i) <= THR) ? 1 : 0);
        end
        chk("drain_end_rempty", {31'b0, rempty}, 1);

        // Underflow: read while empty leaves the pointer alone.
        apply_stimulus(1'b1);
        chk("uflow_rptr", {22'b0, rptr}, gray(5));
        repeat (3) apply_stimulus(1'b0);
        do_reset();

        // Full FIFO seen from rbin=0.
        wbin = 512;
        repeat (3) apply_stimulus(1'b0);
        chk("full_rlevel",  {22'b0, rlevel},  512);
        chk("full_rempty",  {31'b0, rempty},  0);
        chk("full_raempty", {31'b0, raempty}, 0);

        // Wrap: read up to rbin=1023, then one more entry across the wrap.
        guard = 0;
        while (m_rcount != 1023 && guard < 3000) begin
            if (wbin != 1023) wbin++;
            apply_stimulus(1'b1);
            guard++;
        end
        chk("wrap_reached", (guard < 3000) ? 1 : 0, 1);
        wbin = 0;
        repeat (3) apply_stimulus(1'b0);
        chk("wrap_pre_rempty", {31'b0, rempty}, 0);
        apply_stimulus(1'b1);
        chk("wrap_rptr",   {22'b0, rptr},   0);
        chk("wrap_raddr",  {22'b0, raddr},  0);
        chk("wrap_rempty", {31'b0, rempty}, 1);

        // Mid-stream asynchronous reset at rbin=37.
        do_reset();
        wbin = 60;
        repeat (3) apply_stimulus(1'b0);
        repeat (37) apply_stimulus(1'b1);
        chk("mid_raddr", {22'b0, raddr}, 37);
        do_reset();

        // Random traffic against the model.
        wbin = 0;
        for (int n = 0; n < 600; n++) begin
            int occ;
            occ = (wbin - m_rcount + PMOD) % PMOD;
            if (occ < DEPTH && $urandom_range(0, 2) != 0)
                wbin = (wbin + 1) % PMOD;
            apply_stimulus(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
